data_memory_bytelane: RTL and testbench

- Parametrised successor to the single-cycle data memory.
- Word-organised RAM with byte and halfword access for RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Byte-lane write enables, load sign/zero extension, misalignment detection.
- Array cleared by a sequential clear engine rather than a single-cycle loop. Sits between the ALU address output and the writeback mux.

---
 rtl/data_memory_bytelane.sv | 169 ++++++++++++++++
 tb/tb_data_memory_bytelane.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane: word-organised RV32I data memory with byte/halfword
// lanes, load sign/zero extension, misalignment flag and a sequential clear
// engine that sweeps the array one word per cycle after reset or a CLR pulse.
// Optional build macro DMEM_REGISTERED_READ_EN registers RD3, giving one cycle
// of load latency with read-before-write behaviour on same-cycle collisions.
module data_memory_bytelane #(
    parameter int DEPTH = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        CLR,
    output logic [31:0] RD3,
    output logic        BUSY,
    output logic        MISALIGN
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cnt_next;

    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [3:0]       lane_en;
    logic [31:0]      lane_data;
    logic             busy;
    logic             write_ok;
    logic [31:0]      word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;

    // Address bits above the word index alias onto the same words.
    logic [29-IDX_W:0] unused_addr_hi;

    assign idx            = A[IDX_W+1:2];
    assign off            = A[1:0];
    assign unused_addr_hi = A[31:IDX_W+2];

    // The engine state is itself the BUSY flop, so BUSY is a registered output.
    assign busy = (state == CLEAR);
    assign BUSY = busy;

    // Flag misaligned halfword/word accesses, illegal encodings, and
    // unsigned-load encodings used for a store.
    always_comb begin
        MISALIGN = 1'b0;
        case (FUNCT3)
            3'b000:  MISALIGN = 1'b0;
            3'b001:  MISALIGN = A[0];
            3'b010:  MISALIGN = (A[1:0] != 2'b00);
            3'b100:  MISALIGN = WE;
            3'b101:  MISALIGN = WE | A[0];
            default: MISALIGN = 1'b1;
        endcase
    end

    // Work out which byte lanes a store touches and replicate the store data
    // so every selected lane sees its little-endian byte.
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = WD;
        case (FUNCT3)
            3'b000: begin
                lane_en   = 4'b0001 << off;
                lane_data = {4{WD[7:0]}};
            end
            3'b001: begin
                lane_en   = A[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{WD[15:0]}};
            end
            3'b010:  lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    assign write_ok = WE & ~busy & ~MISALIGN;

    // Array write port: the clear sweep owns it while busy, otherwise stores.
    always_ff @(posedge CLK) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (write_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Clear engine state register; reset starts a fresh sweep from word 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Clear engine next state: sweep every word once, ignore CLR while sweeping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            CLEAR: begin
                cnt_next = cnt + IDX_W'(1);
                if (cnt == IDX_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (CLR) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Load path: pick the addressed byte/half and extend it; blank when the
    // access is illegal or the array is being cleared.
    always_comb begin
        word     = mem[idx];
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = A[1] ? word[31:16] : word[15:0];
        load_val = '0;
        if (!busy && !MISALIGN) begin
            case (FUNCT3)
                3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  load_val = {24'h000000, byte_sel};
                3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
                3'b101:  load_val = {16'h0000, half_sel};
                3'b010:  load_val = word;
                default: load_val = '0;
            endcase
        end
    end

`ifdef DMEM_REGISTERED_READ_EN
    // Registered read: capture the load result each edge (old data on collisions).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RD3 <= '0;
        end else begin
            RD3 <= load_val;
        end
    end
`else
    assign RD3 = load_val;
`endif

endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb_data_memory_bytelane: directed bench for data_memory_bytelane (DEPTH=16)
// with a byte-addressed reference model and a per-cycle compare process.
module tb_data_memory_bytelane;

    localparam int DEPTH  = 16;
    localparam int NBYTES = DEPTH * 4;

    logic        CLK;
    logic        RST;
    logic        WE;
    logic [2:0]  FUNCT3;
    logic [31:0] A;
    logic [31:0] WD;
    logic        CLR;
    logic [31:0] RD3;
    logic        BUSY;
    logic        MISALIGN;

    int vectors     = 0;
    int miscompares = 0;
    bit check_on    = 0;

    logic [7:0]  model_bytes [NBYTES];
    int          busy_left;
    logic [31:0] model_rd_q;
    logic [31:0] exp_rd3;
    int          n;

    data_memory_bytelane #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WE       (WE),
        .FUNCT3   (FUNCT3),
        .A        (A),
        .WD       (WD),
        .CLR      (CLR),
        .RD3      (RD3),
        .BUSY     (BUSY),
        .MISALIGN (MISALIGN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tally(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Access legality straight from the RV32I load/store rules.
    function automatic bit misModel(input logic [2:0] f3, input logic [31:0] a, input logic we);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return (a % 4) != 0;
            3'b100:  return we;
            3'b101:  return we || a[0];
            default: return 1'b1;
        endcase
    endfunction

    // Load result from the byte-addressed model memory.
    function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [31:0] a,
                                              input logic we, input bit busy_now);
        int b;
        logic [15:0] h;
        if (busy_now || misModel(f3, a, we)) return 32'h0;
        b = int'(a % 32'(NBYTES));
        case (f3)
            3'b000: return {{24{model_bytes[b][7]}}, model_bytes[b]};
            3'b100: return {24'h0, model_bytes[b]};
            3'b001: begin
                h = {model_bytes[b+1], model_bytes[b]};
                return {{16{h[15]}}, h};
            end
            3'b101: begin
                h = {model_bytes[b+1], model_bytes[b]};
                return {16'h0, h};
            end
            3'b010: return {model_bytes[b+3], model_bytes[b+2], model_bytes[b+1], model_bytes[b]};
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: whole array logically zeroed when a clear starts,
    // accesses blocked for DEPTH cycles while it runs.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy_left  = DEPTH;
            model_rd_q = 32'h0;
            foreach (model_bytes[i]) model_bytes[i] = 8'h00;
        end else begin
            model_rd_q = loadModel(FUNCT3, A, WE, busy_left > 0);
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (WE && !misModel(FUNCT3, A, WE)) begin
                    int b;
                    b = int'(A % 32'(NBYTES));
                    case (FUNCT3)
                        3'b000: model_bytes[b] = WD[7:0];
                        3'b001: begin
                            model_bytes[b]   = WD[7:0];
                            model_bytes[b+1] = WD[15:8];
                        end
                        3'b010: for (int k = 0; k < 4; k++) model_bytes[b+k] = WD[8*k +: 8];
                        default: ;
                    endcase
                end
                if (CLR) begin
                    foreach (model_bytes[i]) model_bytes[i] = 8'h00;
                    busy_left = DEPTH;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (check_on) begin
`ifdef DMEM_REGISTERED_READ_EN
            exp_rd3 = model_rd_q;
`else
            exp_rd3 = loadModel(FUNCT3, A, WE, busy_left > 0);
`endif
            tally("model_busy", {31'h0, BUSY}, {31'h0, busy_left > 0});
            tally("model_misalign", {31'h0, MISALIGN}, {31'h0, misModel(FUNCT3, A, WE)});
            tally("model_rd3", RD3, exp_rd3);
        end
    end

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic clr);
        @(posedge CLK);
        #1;
        WE     = we;
        FUNCT3 = f3;
        A      = a;
        WD     = wd;
        CLR    = clr;
    endtask

    // which: 0 = RD3, 1 = MISALIGN, 2 = BUSY
    task automatic checkOutput(input string name, input int which, input logic [31:0] exp);
        @(negedge CLK);
        #1;
        case (which)
            0:       tally(name, RD3, exp);
            1:       tally(name, {31'h0, MISALIGN}, exp);
            default: tally(name, {31'h0, BUSY}, exp);
        endcase
    endtask

    task automatic loadCheck(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp);
        applyStimulus(1'b0, f3, a, 32'h0, 1'b0);
`ifdef DMEM_REGISTERED_READ_EN
        applyStimulus(1'b0, f3, a, 32'h0, 1'b0);
`endif
        checkOutput(name, 0, exp);
    endtask

    task automatic illegalStore(input string name, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd);
        applyStimulus(1'b1, f3, a, wd, 1'b0);
        checkOutput({name, "_flag"}, 1, 32'h1);
`ifdef DMEM_REGISTERED_READ_EN
        applyStimulus(1'b1, f3, a, wd, 1'b0);
`endif
        checkOutput({name, "_rd3"}, 0, 32'h0);
    endtask

    // Count cycles with BUSY high; optionally poke CLR or a store mid-sweep.
    task automatic countBusy(input int poke_at, input bit poke_clr, output int cycles);
        cycles = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            #1;
            if (!BUSY) break;
            cycles++;
            @(posedge CLK);
            #1;
            WE = 1'b0; CLR = 1'b0; FUNCT3 = 3'b010; A = 32'h0; WD = 32'h0;
            if (i == poke_at) begin
                if (poke_clr) begin
                    CLR = 1'b1;
                end else begin
                    WE = 1'b1; A = 32'h8; WD = 32'hDEADBEEF;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1; WE = 1'b0; FUNCT3 = 3'b010; A = 32'h0; WD = 32'h0; CLR = 1'b0;
        #2 RST = 1'b0;
        check_on = 1'b1;
        repeat (3) @(posedge CLK);
        checkOutput("busy_in_reset", 2, 32'h1);
        checkOutput("rd3_in_reset", 0, 32'h0);

        // Reset release: 16 busy cycles, a store at cycle 5 is dropped.
        @(posedge CLK);
        #1 RST = 1'b1;
        countBusy(4, 1'b0, n);
        tally("busy_len_reset", n, 32'd16);
        for (int w = 0; w < DEPTH; w++)
            loadCheck($sformatf("zero_w%0d", w), 3'b010, 32'(w * 4), 32'h0);

        // Extension of byte and halfword loads.
        applyStimulus(1'b1, 3'b010, 32'h40, 32'h800000F1, 1'b0);
        loadCheck("lb_40",  3'b000, 32'h40, 32'hFFFFFFF1);
        loadCheck("lbu_40", 3'b100, 32'h40, 32'h000000F1);
        loadCheck("lh_40",  3'b001, 32'h40, 32'h000000F1);
        loadCheck("lhu_40", 3'b101, 32'h40, 32'h000000F1);
        loadCheck("lw_40",  3'b010, 32'h40, 32'h800000F1);
        loadCheck("lh_42",  3'b001, 32'h42, 32'hFFFF8000);
        loadCheck("lhu_42", 3'b101, 32'h42, 32'h00008000);

        // Partial-lane stores leave other lanes intact.
        applyStimulus(1'b1, 3'b010, 32'h40, 32'h11223344, 1'b0);
        applyStimulus(1'b1, 3'b000, 32'h41, 32'h000000AB, 1'b0);
        loadCheck("sb_41", 3'b010, 32'h40, 32'h1122AB44);
        applyStimulus(1'b1, 3'b001, 32'h42, 32'h0000BEEF, 1'b0);
        loadCheck("sh_42", 3'b010, 32'h40, 32'hBEEFAB44);
        loadCheck("lb_43", 3'b000, 32'h43, 32'hFFFFFFBE);

        // Misaligned and illegal stores write nothing.
        illegalStore("mis_sw_06", 3'b010, 32'h06, 32'hFFFFFFFF);
        loadCheck("w1_unchanged", 3'b010, 32'h04, 32'h0);
        illegalStore("mis_sh_03", 3'b001, 32'h03, 32'h00001234);
        loadCheck("w0_after_sh03", 3'b010, 32'h00, 32'hBEEFAB44);
        illegalStore("ill_f3_011", 3'b011, 32'h40, 32'h0);
        illegalStore("ill_sbu", 3'b100, 32'h40, 32'h0);
        loadCheck("w0_after_ill", 3'b010, 32'h40, 32'hBEEFAB44);

        // Store/load collision on one word.
        applyStimulus(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b0);
`ifdef DMEM_REGISTERED_READ_EN
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
        checkOutput("rbw_old", 0, 32'hBEEFAB44);
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
        checkOutput("rbw_new", 0, 32'hCAFEF00D);
`else
        checkOutput("rbw_old", 0, 32'hBEEFAB44);
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
        checkOutput("rbw_new", 0, 32'hCAFEF00D);
`endif
        applyStimulus(1'b1, 3'b010, 32'h14, 32'h55AA55AA, 1'b0);
        loadCheck("w5", 3'b010, 32'h14, 32'h55AA55AA);

        // CLR sweep with a second CLR mid-sweep.
        applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 1'b1);
        checkOutput("clr_cycle_busy", 2, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        countBusy(7, 1'b1, n);
        tally("busy_len_clr", n, 32'd16);
        loadCheck("w0_cleared", 3'b010, 32'h40, 32'h0);
        loadCheck("w5_cleared", 3'b010, 32'h14, 32'h0);

        // Reset in the middle of a sweep restarts the count.
        applyStimulus(1'b1, 3'b010, 32'h14, 32'h12345678, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        repeat (6) applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b0;
        checkOutput("busy_mid_rst", 2, 32'h1);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        countBusy(99, 1'b0, n);
        tally("busy_len_rst_mid", n, 32'd16);
        for (int w = 0; w < DEPTH; w++)
            loadCheck($sformatf("final_zero_w%0d", w), 3'b010, 32'(w * 4), 32'h0);

        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        @(negedge CLK);
        check_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
